pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//   Parametrised inter-stage pipeline register for the MIPS datapath (F/D/E/M/W boundaries).
//   It replaces the fixed single-payload stage regs with a LANES-wide (multi-issue) payload register.
//   Flow control is a valid/ready handshake; flush kills the held beats.
//   Sits between a producing stage's *_new output and the consuming stage's input.
// PARAMETERS
//   WIDTH       32   payload bits per lane
//   LANES       1    issue lanes carried per beat (1..4)
//   RESET_DATA  '0   value of every lane of out_data after reset
// PORTS
//   clk            in   1            rising-edge clock
//   reset          in   1            asynchronous, active-high reset
//   flush          in   1            synchronous kill of all held beats (hazard unit)
//   in_valid       in   1            producer offers a beat
//   in_ready       out  1            register accepts a beat this cycle
//   in_lane_valid  in   LANES        per-lane instruction valid
//   in_data        in   LANES*WIDTH  lane i at [i*WIDTH +: WIDTH]
//   out_valid      out  1            beat presented to consumer
//   out_ready      in   1            consumer takes the beat this cycle
//   out_lane_valid out  LANES        per-lane valid of the presented beat
//   out_data       out  LANES*WIDTH  presented payload
// BEHAVIOUR
//   - Handshake rules:
//     - Accept = in_valid & in_ready. Emit = out_valid & out_ready.
//     - Latency from accept to out_valid is 1 cycle.
//     - A beat with in_lane_valid==0 is still a beat; it is forwarded unchanged.
//   - Reset (async, any time, including mid-transfer):
//     - state=EMPTY; out_valid=0, out_lane_valid=0, out_data=RESET_DATA.
//     - in_ready=1; skid entry invalid.
//   - Output stability: while out_valid & !out_ready, out_data and out_lane_valid hold.
//   - out_lane_valid is forced to 0 whenever out_valid=0.
//   - flush has highest priority:
//     - next state=EMPTY, all valids cleared, any same-cycle accept discarded.
//     - Payload regs keep their values (don't-care).
//   - State machine, skid mode (states EMPTY / BUSY / FULL):
//     - EMPTY: out_valid=0. On accept, main<=in, go to BUSY.
//     - BUSY, accept & emit: main<=in, stay BUSY.
//     - BUSY, accept & !emit: skid<=in, go to FULL.
//     - BUSY, !accept & emit: go to EMPTY.
//     - FULL: in_ready=0. On emit, main<=skid, go to BUSY.
//     - in_ready is a flop output: 1 iff next state != FULL.
//   - Non-skid mode (EMPTY / BUSY only):
//     - in_ready = !out_valid | out_ready (combinational).
//     - Accept loads main; emit without accept goes to EMPTY.
//   - No beat is ever duplicated or dropped except by flush; order is strictly FIFO.
// CONFIGURATION
//   PIPE_STAGE_REG_SKID_EN defined:
//     - 2-entry skid mode as above; in_ready is registered.
//     - No combinational path from out_ready to in_ready.
//     - Full throughput.
//   Not defined:
//     - Single-entry mode; in_ready depends combinationally on out_ready.
//     - No skid storage, no FULL state.
// TESTING
//   1. Reset: assert reset mid-beat -> same cycle out_valid=0, in_ready=1, out_data=RESET_DATA.
//   2. Streaming: in_valid=1, out_ready=1, data 1,2,3..10 -> out emits 1..10 one per cycle, 1-cycle latency, no gaps.
//   3. Backpressure (SKID_EN): out_ready=0 while sending 0xA, 0xB -> in_ready=0 after 2nd accept;
//      out holds 0xA; out_ready=1 -> 0xA then 0xB.
//   4. Flush in FULL with in_valid=1 (data 0xC) -> next cycle out_valid=0, out_lane_valid=0; 0xC never appears.
//   5. LANES=2, in_lane_valid=2'b10, data {0x5,0x7} -> out_lane_valid=2'b10, lane1=0x5, lane0=0x7.
//   6. Non-skid build: out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Inter-stage pipeline register for the MIPS datapath (F/D/E/M/W boundaries).
//   It carries a LANES-wide payload with per-lane instruction valids. A
//   valid/ready handshake controls flow. A flush kills every held beat.
//
// Configuration macro: PIPE_STAGE_REG_SKID_EN
//   defined   : 2-entry skid buffer (EMPTY/BUSY/FULL). in_ready is a flop, so
//               there is no combinational path from out_ready to in_ready.
//               Throughput is one beat per cycle.
//   undefined : single-entry register (EMPTY/BUSY).
//               in_ready = !out_valid | out_ready, which is combinational.
//
// Parameters
//   WIDTH       payload bits per lane
//   LANES       issue lanes per beat (1..4)
//   RESET_DATA  per-lane value of out_data after reset
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   flush          synchronous kill of all held beats (highest priority)
//   in_valid       producer offers a beat
//   in_ready       register accepts a beat this cycle
//   in_lane_valid  per-lane instruction valid of the offered beat
//   in_data        offered payload, lane i at [i*WIDTH +: WIDTH]
//   out_valid      beat presented to consumer
//   out_ready      consumer takes the beat this cycle
//   out_lane_valid per-lane valid of the presented beat (0 when !out_valid)
//   out_data       presented payload
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int               WIDTH      = 32,
  parameter int               LANES      = 1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES-1:0]       in_lane_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_lane_valid,
  output logic [LANES*WIDTH-1:0] out_data
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]             r_state;
  logic [1:0]             w_state_next;
  logic [LANES*WIDTH-1:0] r_main_data;
  logic [LANES-1:0]       r_main_lv;
  logic [LANES*WIDTH-1:0] w_reset_data;
  logic                   w_accept;
  logic                   w_emit;
  logic                   w_load_main_in;

  // Replicate the per-lane reset value across every lane.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_reset_data
    assign w_reset_data[gi*WIDTH +: WIDTH] = RESET_DATA;
  end

  assign out_valid      = (r_state != ST_EMPTY);
  assign out_lane_valid = out_valid ? r_main_lv : '0;
  assign out_data       = r_main_data;
  assign w_accept       = in_valid & in_ready;
  assign w_emit         = out_valid & out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic [LANES*WIDTH-1:0] r_skid_data;
  logic [LANES-1:0]       r_skid_lv;
  logic                   r_in_ready;
  logic                   w_load_main_skid;
  logic                   w_load_skid;

  assign in_ready = r_in_ready;

  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_load_main_in = 1'b1;
            w_state_next   = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_accept && w_emit) begin
            w_load_main_in = 1'b1;
          end else if (w_accept) begin
            // The consumer stalled, so park the new beat behind the held one.
            w_load_skid  = 1'b1;
            w_state_next = ST_FULL;
          end else if (w_emit) begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_emit) begin
            w_load_main_skid = 1'b1;
            w_state_next     = ST_BUSY;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid_data <= '0;
      r_skid_lv   <= '0;
      r_in_ready  <= 1'b1;
    end else begin
      // in_ready is decided one cycle ahead from the next state.
      r_in_ready <= (w_state_next != ST_FULL);
      if (flush) begin
        r_skid_lv <= '0;
      end else if (w_load_skid) begin
        r_skid_data <= in_data;
        r_skid_lv   <= in_lane_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_data <= w_reset_data;
      r_main_lv   <= '0;
    end else if (flush) begin
      r_main_lv <= '0;
    end else if (w_load_main_in) begin
      r_main_data <= in_data;
      r_main_lv   <= in_lane_valid;
    end else if (w_load_main_skid) begin
      r_main_data <= r_skid_data;
      r_main_lv   <= r_skid_lv;
    end
  end
`else
  // The register can take a beat when it is empty or is being drained.
  assign in_ready = (r_state == ST_EMPTY) | out_ready;

  always_comb begin
    w_state_next   = r_state;
    w_load_main_in = 1'b0;
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else if (w_accept) begin
      w_load_main_in = 1'b1;
      w_state_next   = ST_BUSY;
    end else if (w_emit) begin
      w_state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_data <= w_reset_data;
      r_main_lv   <= '0;
    end else if (flush) begin
      r_main_lv <= '0;
    end else if (w_load_main_in) begin
      r_main_data <= in_data;
      r_main_lv   <= in_lane_valid;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

endmodule
